sipo_framer: RTL
================

Name: sipo_framer

Overview:
- Parametrised serial-in/parallel-out deserialiser for the serial-adder datapath; next generation of the 4-bit SIPO.
- Width is configurable, with selectable LSB-first or MSB-first bit order.
- Frames back-to-back with no dead cycle and an explicit re-sync input.
- Delivers words over a valid/ready handshake, with sticky overrun detection and a wrapping word counter.

Parameters:
- WIDTH, 8: parallel word width in bits; legal range 2..32.
- LSB_FIRST, 1: 1 = first received bit lands in out_data[0]; 0 = first received bit lands in out_data[WIDTH-1].
- CNT_W, 8: width of the delivered-word counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset (reset=0 resets on the clk edge).
- a  in  1  serial data bit.
- shift  in  1  sample a this cycle.
- sync  in  1  discard partial word and restart framing at bit 0.
- out_data  out  WIDTH  assembled word, held stable while out_valid=1.
- out_valid  out  1  out_data holds an undelivered word.
- out_ready  in  1  consumer accepts the word when out_valid=1.
- bit_cnt  out  $clog2(WIDTH+1)  bits accumulated in the current partial word.
- word_cnt  out  CNT_W  words delivered (handshakes completed); wraps modulo 2^CNT_W.
- overrun  out  1  sticky: a completed word was dropped.
- clr_ovr  in  1  clears overrun.

Behaviour:
- Reset (reset=0 at edge): shift register=0, bit_cnt=0, out_data=0, out_valid=0, word_cnt=0, overrun=0. Reset overrides every other input, including mid-word and mid-handshake.
- Accumulation, LSB_FIRST=1:
  - Each cycle with shift=1, shift the register right and insert a at the MSB.
  - After WIDTH bits, the first bit is in bit 0.
- Accumulation, LSB_FIRST=0:
  - Each cycle with shift=1, shift the register left and insert a at the LSB.
- No shift while shift=0; bit_cnt holds.
- Completion:
  - The cycle in which the WIDTH-th bit is sampled (bit_cnt==WIDTH-1 && shift) is the completion cycle.
  - bit_cnt returns to 0 that edge.
  - The next word starts with no bubble on the following cycle.
- Latency: the assembled word appears on out_data with out_valid=1 on the edge that samples the last bit. Combinational-free path: out_data is registered.
- Handshake:
  - The transfer occurs on an edge where out_valid && out_ready.
  - word_cnt increments on each transfer.
  - out_valid falls after the transfer unless a new word completes on the same edge; it then stays 1 with the new data.
- Overrun:
  - Condition: a word completes while out_valid=1 && out_ready=0.
  - The new word is dropped, out_data is retained, overrun is set, and word_cnt is unchanged.
- Clearing overrun:
  - clr_ovr=1 clears overrun.
  - If a new overrun occurs in the same cycle, set wins.
- sync=1:
  - Partial-word contents are discarded and bit_cnt=0.
  - If shift=1 in the same cycle, that bit is taken as bit 0 of the new word (bit_cnt=1 after the edge).
  - sync does not affect out_valid, out_data, overrun or word_cnt.
  - With WIDTH-1 bits pending, sync+shift never produces a completion.
- Bit order in out_data is defined by reception order only; the register contents outside completed words are unspecified except after reset (all 0).
- word_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Unknown inputs are not supported; out_ready is ignored while out_valid=0.

Decomposition:
- Package sipo_pkg:
  - default constants SIPO_WIDTH_DEF=8 and SIPO_CNT_W_DEF=8.
  - localparam function for the bit_cnt width ($clog2(WIDTH+1)).
  - enum for bit order: ORDER_LSB_FIRST=1, ORDER_MSB_FIRST=0.
- Sub-module sipo_shift_core: the shift register and bit counter, with sync/shift handling and a one-cycle done pulse plus word output.
- The top level (sipo_framer) holds the output register, handshake, overrun and word_cnt.

Test Plan:
- WIDTH=8, LSB_FIRST=1, out_ready=1; shift 8 bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data=8'h4D, out_valid=1 the edge after the 8th bit, word_cnt=1.
- Same bit stream with LSB_FIRST=0 -> out_data=8'hB2.
- 24 consecutive shift cycles carrying 8'hA5, 8'h3C, 8'hFF with out_ready=1 -> three words, no gaps, each valid exactly one cycle, word_cnt=3.
- out_ready=0; send 8'h11 then 8'h22 -> out_data stays 8'h11 and overrun=1. Then raise out_ready -> 8'h11 delivered; pulse clr_ovr -> overrun=0.
- Send 5 bits, then sync+shift with a=1, then 7 more bits -> exactly one word, whose first bit is the sync-cycle bit; bit_cnt=1 after sync.
- Assert reset=0 mid-word (bit_cnt=5) with out_valid=1 -> next cycle all outputs 0. A subsequent clean 8-bit frame decodes correctly.

Source files
------------

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared constants, bit-order enum and counter-width helper
//               for the sipo_framer deserialiser.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    localparam int SIPO_WIDTH_DEF = 8;
    localparam int SIPO_CNT_W_DEF = 8;

    // Which end of the parallel word the first received bit lands in
    typedef enum logic {
        ORDER_MSB_FIRST = 1'b0,
        ORDER_LSB_FIRST = 1'b1
    } bit_order_e;

    // Width needed to count 0..width accumulated bits
    function automatic int sipo_bcnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift_core
// Description : Shift register and bit counter. Raises a combinational done
//               pulse in the cycle the last bit is sampled, with the fully
//               assembled word alongside it.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int         WIDTH  = SIPO_WIDTH_DEF,
    parameter bit_order_e ORDER  = ORDER_LSB_FIRST,
    localparam int        BCNT_W = sipo_bcnt_w(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a,
    input  logic              shift,
    input  logic              sync,
    output logic [BCNT_W-1:0] bit_cnt,
    output logic              done,
    output logic [WIDTH-1:0]  word
);

    localparam logic [BCNT_W-1:0] c_last_bit = BCNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]  r_sr;
    logic [BCNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]  w_base;
    logic [WIDTH-1:0]  w_next;

    // A sync throws away the partial word before the new bit is inserted
    assign w_base = sync ? '0 : r_sr;

    generate
        if (ORDER == ORDER_LSB_FIRST) begin : g_lsb_first
            assign w_next = {a, w_base[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_next = {w_base[WIDTH-2:0], a};
        end
    endgenerate

    // sync restarts framing, so it can never complete a word
    assign done    = shift && !sync && (r_cnt == c_last_bit);
    assign word    = w_next;
    assign bit_cnt = r_cnt;

    // Shift register and bit counter update
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else begin
            if (shift) begin
                r_sr <= w_next;
            end else if (sync) begin
                r_sr <= '0;
            end

            if (sync) begin
                r_cnt <= shift ? BCNT_W'(1) : '0;
            end else if (shift) begin
                r_cnt <= done ? '0 : r_cnt + BCNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sipo_framer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_framer
// Description : Parametrised serial-in/parallel-out framer with valid/ready
//               output, sticky overrun flag and wrapping word counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_framer
    import sipo_pkg::*;
#(
    parameter int  WIDTH     = SIPO_WIDTH_DEF,
    parameter int  LSB_FIRST = 1,
    parameter int  CNT_W     = SIPO_CNT_W_DEF,
    localparam int BCNT_W    = sipo_bcnt_w(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a,
    input  logic              shift,
    input  logic              sync,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BCNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              overrun,
    input  logic              clr_ovr
);

    localparam bit_order_e c_order = (LSB_FIRST != 0) ? ORDER_LSB_FIRST : ORDER_MSB_FIRST;

    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic             w_xfer;
    logic             w_drop;

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_wcnt;
    logic             r_ovr;

    sipo_shift_core #(
        .WIDTH (WIDTH),
        .ORDER (c_order)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .shift   (shift),
        .sync    (sync),
        .bit_cnt (bit_cnt),
        .done    (w_done),
        .word    (w_word)
    );

    assign w_xfer = r_valid && out_ready;
    // A word completing while the previous one is still stuck is lost
    assign w_drop = w_done && r_valid && !out_ready;

    // Output register, handshake, overrun flag and delivered-word counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_wcnt  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_wcnt <= r_wcnt + CNT_W'(1);
            end

            if (w_done && !w_drop) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign word_cnt  = r_wcnt;
    assign overrun   = r_ovr;

endmodule
`default_nettype wire
